// File: rtl/hwpe_stream_sig_sink_if.sv
// -----------------------------------------------------------------------------
// hwpe_stream_intf_stream
// Valid/ready stream bundle used between stream producers and consumers.
//   valid : producer has a beat on data/strb
//   ready : consumer accepts the beat this cycle
//   data  : DATA_WIDTH payload
//   strb  : one enable bit per payload byte
// Modports: source (producer side), sink (consumer side).
// -----------------------------------------------------------------------------
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_sig_sink.sv
// -----------------------------------------------------------------------------
// hwpe_stream_sig_sink
// Stream sink that terminates a stream producer with LFSR-driven pseudo-random
// backpressure and compresses every accepted beat into a 32-bit rotating
// signature. After a programmed number of beats it reports the beat count, the
// signature and whether it equals an expected value.
//
// Ports:
//   clk_i          : clock (single domain)
//   rst_ni         : asynchronous active-low reset
//   clear_i        : synchronous soft clear, back to IDLE, zeroes results/err
//   start_i        : start a transfer (accepted in IDLE and DONE)
//   expected_len_i : beats to accept, latched on start
//   expected_sig_i : expected final signature, latched on start
//   stall_thr_i    : backpressure threshold, 0 = never stall
//   push_i         : input stream (sink modport)
//   busy_o         : transfer running
//   done_o         : transfer finished, results held
//   match_o        : signature equals expected (only meaningful with done_o)
//   signature_o    : running signature
//   beat_cnt_o     : beats accepted since start
//   err_o          : sticky stream protocol error
//
// Build option: define HWPE_STREAM_SIG_SINK_PROTOCOL_CHECK_EN to build the
// stream protocol checker; otherwise err_o is tied low.
// -----------------------------------------------------------------------------
module hwpe_stream_sig_sink #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] expected_len_i,
    input  logic [31:0]          expected_sig_i,
    input  logic [7:0]           stall_thr_i,
    hwpe_stream_intf_stream.sink push_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 match_o,
    output logic [31:0]          signature_o,
    output logic [CNT_WIDTH-1:0] beat_cnt_o,
    output logic                 err_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned N_CHUNK    = (DATA_WIDTH + 31) / 32;
    localparam int unsigned PAD_WIDTH  = N_CHUNK * 32;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte-mask the beat, then XOR all 32-bit chunks; the top chunk is
    // zero-padded when DATA_WIDTH is not a multiple of 32.
    function automatic logic [31:0] fold_beat(
        input logic [DATA_WIDTH-1:0] data,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [PAD_WIDTH-1:0] padded;
        logic [31:0]          acc;
        padded = '0;
        for (int k = 0; k < int'(STRB_WIDTH); k++) begin
            padded[8*k +: 8] = strb[k] ? data[8*k +: 8] : 8'h00;
        end
        acc = 32'h0000_0000;
        for (int c = 0; c < int'(N_CHUNK); c++) begin
            acc = acc ^ padded[32*c +: 32];
        end
        return acc;
    endfunction

    state_e               r_state;
    logic [15:0]          r_lfsr;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [31:0]          r_sig;
    logic [CNT_WIDTH-1:0] r_len;
    logic [31:0]          r_exp_sig;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_match;

    state_e               w_state_next;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [31:0]          w_sig_next;
    logic [CNT_WIDTH-1:0] w_len_next;
    logic [31:0]          w_exp_sig_next;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_beat;
    logic                 w_lfsr_fb;
    logic [15:0]          w_lfsr_next;
    logic                 w_ready_next;
    logic                 w_match_next;

    // r_ready is only ever high in RUN, so it alone qualifies the handshake.
    assign w_beat    = push_i.valid & r_ready;
    assign w_cnt_inc = r_cnt + CNT_ONE;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1 (right shift, taps 0/2/3/5),
    // advancing only while a transfer runs.
    assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_lfsr_next = (r_state == ST_RUN) ? {w_lfsr_fb, r_lfsr[15:1]} : r_lfsr;

    // Next-state, counter, signature and latched-expectation logic.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_sig_next     = r_sig;
        w_len_next     = r_len;
        w_exp_sig_next = r_exp_sig;
        if (clear_i) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_sig_next   = 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        w_len_next     = expected_len_i;
                        w_exp_sig_next = expected_sig_i;
                        w_cnt_next     = '0;
                        w_sig_next     = 32'h0000_0000;
                        if (expected_len_i == '0) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_state_next = ST_RUN;
                        end
                    end else begin
                        w_state_next = r_state;
                    end
                end
                ST_RUN: begin
                    if (w_beat) begin
                        w_cnt_next = w_cnt_inc;
                        w_sig_next = {r_sig[30:0], r_sig[31]} ^ fold_beat(push_i.data, push_i.strb);
                        if (w_cnt_inc == r_len) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_state_next = ST_RUN;
                        end
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Ready and match are computed from next-state values so that the
    // outputs are plain flops with no path from push_i.valid to ready.
    assign w_ready_next = (w_state_next == ST_RUN) && (w_lfsr_next[7:0] >= stall_thr_i);
    assign w_match_next = (w_state_next == ST_DONE) && (w_sig_next == w_exp_sig_next);

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_cnt     <= '0;
            r_sig     <= 32'h0000_0000;
            r_len     <= '0;
            r_exp_sig <= 32'h0000_0000;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_match   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_lfsr    <= w_lfsr_next;
            r_cnt     <= w_cnt_next;
            r_sig     <= w_sig_next;
            r_len     <= w_len_next;
            r_exp_sig <= w_exp_sig_next;
            r_ready   <= w_ready_next;
            r_busy    <= (w_state_next == ST_RUN);
            r_done    <= (w_state_next == ST_DONE);
            r_match   <= w_match_next;
        end
    end

    assign push_i.ready = r_ready;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign match_o      = r_match;
    assign signature_o  = r_sig;
    assign beat_cnt_o   = r_cnt;

`ifdef HWPE_STREAM_SIG_SINK_PROTOCOL_CHECK_EN
    logic                  r_stalled;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic [STRB_WIDTH-1:0] r_hold_strb;
    logic                  r_err;
    logic                  w_stall_now;
    logic                  w_violation;

    // A stalled beat (valid without ready) must be re-offered unchanged.
    assign w_stall_now = (r_state == ST_RUN) && push_i.valid && !r_ready;
    assign w_violation = (r_state == ST_RUN) && r_stalled &&
                         (!push_i.valid || (push_i.data != r_hold_data) ||
                          (push_i.strb != r_hold_strb));

    // Remember the stalled beat and accumulate the sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stalled   <= 1'b0;
            r_hold_data <= '0;
            r_hold_strb <= '0;
            r_err       <= 1'b0;
        end else if (clear_i) begin
            r_stalled   <= 1'b0;
            r_hold_data <= '0;
            r_hold_strb <= '0;
            r_err       <= 1'b0;
        end else begin
            r_stalled   <= w_stall_now;
            r_hold_data <= push_i.data;
            r_hold_strb <= push_i.strb;
            r_err       <= r_err | w_violation;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hwpe_stream_sig_sink.sv
module tb_hwpe_stream_sig_sink;

    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int CW = 16;
    localparam int BEAT_BUDGET = 8000;
`ifdef HWPE_STREAM_SIG_SINK_PROTOCOL_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] expected_len_i = '0;
    logic [31:0]   expected_sig_i = 32'h0;
    logic [7:0]    stall_thr_i = 8'h00;
    logic          busy_o, done_o, match_o, err_o;
    logic [31:0]   signature_o;
    logic [CW-1:0] beat_cnt_o;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_s ();

    hwpe_stream_sig_sink #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .LFSR_SEED(16'hACE1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .expected_len_i(expected_len_i), .expected_sig_i(expected_sig_i),
        .stall_thr_i(stall_thr_i), .push_i(push_s),
        .busy_o(busy_o), .done_o(done_o), .match_o(match_o),
        .signature_o(signature_o), .beat_cnt_o(beat_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] beat_d[$];
    logic [SW-1:0] beat_s[$];

    function automatic logic [31:0] model_fold(input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] m;
        logic [31:0]   r;
        m = d;
        for (int k = 0; k < SW; k++) if (!s[k]) m[8*k +: 8] = 8'h00;
        r = 32'h0;
        for (int c = 0; c < DW; c += 32) r = r ^ m[c +: 32];
        return r;
    endfunction

    function automatic logic [31:0] model_sig();
        logic [31:0] sig;
        sig = 32'h0;
        for (int i = 0; i < beat_d.size(); i++)
            sig = {sig[30:0], sig[31]} ^ model_fold(beat_d[i], beat_s[i]);
        return sig;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [CW-1:0] cnt;
        logic [31:0]   sig;
        logic          match;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    logic mon_prev_done = 1'b0;
    logic mon_prev_start = 1'b0;

    always @(negedge clk) begin
        if (!rst_ni) begin
            mon_prev_done  = 1'b0;
            mon_prev_start = 1'b0;
        end else begin
            check("ready_only_in_run", push_s.ready & ~busy_o, 1'b0);
            if (done_o && (!mon_prev_done || mon_prev_start)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done expected=no_result_pending");
                end else begin
                    mon_e = sb_q.pop_front();
                    check("done_cnt", beat_cnt_o, mon_e.cnt);
                    check("done_sig", signature_o, mon_e.sig);
                    check("done_match", match_o, mon_e.match);
                end
            end else if (!done_o) begin
                check("match_gated", match_o, 1'b0);
            end
            mon_prev_done  = done_o;
            mon_prev_start = start_i;
        end
    end

    // ---------------- driver ----------------
    // Offers every queued beat, holding it until accepted; optional idle gaps.
    task automatic send_beats(input bit gaps, output int cycles, output bit ok);
        logic acc;
        int   w;
        cycles = 0;
        ok = 1'b1;
        for (int i = 0; i < beat_d.size(); i++) begin
            push_s.valid = 1'b1;
            push_s.data  = beat_d[i];
            push_s.strb  = beat_s[i];
            acc = 1'b0;
            w = 0;
            while (!acc) begin
                @(negedge clk);
                acc = push_s.ready;
                @(posedge clk);
                #1;
                cycles++;
                w++;
                if (!acc && w >= BEAT_BUDGET) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_timeout actual=no_ready_in_%0d_cycles expected=accept", w);
                    push_s.valid = 1'b0;
                    ok = 1'b0;
                    return;
                end
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                push_s.valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        push_s.valid = 1'b0;
    endtask

    task automatic do_start(input int len, input logic [31:0] exp_sig, input logic [7:0] thr);
        stall_thr_i    = thr;
        expected_len_i = CW'(len);
        expected_sig_i = exp_sig;
        start_i        = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic run_transfer(input logic [31:0] true_sig, input logic [31:0] exp_sig,
                                input logic [7:0] thr, input bit gaps, output int cycles);
        exp_t e;
        bit   ok;
        int   len;
        len = beat_d.size();
        e.cnt = CW'(len);
        e.sig = true_sig;
        e.match = (true_sig == exp_sig);
        sb_q.push_back(e);
        do_start(len, exp_sig, thr);
        cycles = 0;
        if (len == 0) begin
            @(negedge clk);
            check("len0_done", done_o, 1'b1);
            check("len0_ready", push_s.ready, 1'b0);
            check("len0_sig", signature_o, 32'h0);
            @(posedge clk);
            #1;
        end else begin
            send_beats(gaps, cycles, ok);
            if (ok) begin
                @(negedge clk);
                check("final_done", done_o, 1'b1);
                check("final_busy", busy_o, 1'b0);
                check("final_ready", push_s.ready, 1'b0);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic one_beat(input logic [DW-1:0] d, input logic [SW-1:0] s);
        beat_d.push_back(d);
        beat_s.push_back(s);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int          cyc;
        bit          ok;
        logic [31:0] tsig;
        logic [31:0] esig;
        logic        r;
        int          n;

        push_s.valid = 1'b0;
        push_s.data  = '0;
        push_s.strb  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_match", match_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_ready", push_s.ready, 1'b0);
        check("rst_sig", signature_o, 32'h0);
        check("rst_cnt", beat_cnt_o, 16'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Two beats 0x1, 0x4, full strobe, no stall: signature 0x6.
        beat_d.delete(); beat_s.delete();
        one_beat(64'h1, 8'hFF);
        one_beat(64'h4, 8'hFF);
        run_transfer(32'h6, 32'h6, 8'h00, 1'b0, cyc);
        check("thr0_throughput", cyc, 2);
        run_transfer(32'h6, 32'h7, 8'h00, 1'b0, cyc);

        // Partial strobe keeps only the low two bytes.
        beat_d.delete(); beat_s.delete();
        one_beat(64'hFFFF_FFFF, 8'h03);
        run_transfer(32'h0000_FFFF, 32'h0000_FFFF, 8'h00, 1'b0, cyc);

        // Two 32-bit halves folded together: 5 ^ 3.
        beat_d.delete(); beat_s.delete();
        one_beat(64'h0000_0003_0000_0005, 8'hFF);
        run_transfer(32'h6, 32'h6, 8'h00, 1'b0, cyc);

        // Zero-length transfer from DONE.
        beat_d.delete(); beat_s.delete();
        run_transfer(32'h0, 32'h0, 8'h00, 1'b0, cyc);

        // Sustained throughput with a longer burst.
        beat_d.delete(); beat_s.delete();
        for (int i = 0; i < 20; i++) one_beat({$urandom, $urandom}, SW'($urandom_range(0, 255)));
        tsig = model_sig();
        run_transfer(tsig, tsig, 8'h00, 1'b0, cyc);
        check("thr0_throughput_20", cyc, 20);

        // Randomized transfers.
        for (int t = 0; t < 12; t++) begin
            beat_d.delete(); beat_s.delete();
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) one_beat({$urandom, $urandom}, SW'($urandom_range(0, 255)));
            tsig = model_sig();
            esig = ($urandom_range(0, 1) == 0) ? tsig : (tsig ^ (32'h1 << $urandom_range(0, 31)));
            run_transfer(tsig, esig, ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 200)),
                         1'b1, cyc);
        end

        // Heavy backpressure: ready about once every 256 cycles.
        beat_d.delete(); beat_s.delete();
        for (int i = 0; i < 100; i++) one_beat({$urandom, $urandom}, 8'hFF);
        tsig = model_sig();
        run_transfer(tsig, tsig, 8'hFF, 1'b0, cyc);
        check("thrFF_duty_in_range", (cyc >= 100 * 128) && (cyc <= 100 * 512), 1'b1);

        // Clear mid-transfer, with a beat offered in the clear cycle.
        beat_d.delete(); beat_s.delete();
        for (int i = 0; i < 5; i++) one_beat({$urandom, $urandom}, 8'hFF);
        do_start(40, 32'h0, 8'h00);
        send_beats(1'b0, cyc, ok);
        @(negedge clk);
        check("pre_clear_busy", busy_o, 1'b1);
        check("pre_clear_cnt", beat_cnt_o, 16'd5);
        @(posedge clk);
        #1;
        push_s.valid = 1'b1;
        push_s.data  = {$urandom, $urandom};
        push_s.strb  = 8'hFF;
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        push_s.valid = 1'b0;
        @(negedge clk);
        check("clear_busy", busy_o, 1'b0);
        check("clear_done", done_o, 1'b0);
        check("clear_cnt", beat_cnt_o, 16'h0);
        check("clear_sig", signature_o, 32'h0);
        check("clear_ready", push_s.ready, 1'b0);
        @(posedge clk);
        #1;

        // Protocol violations: mode 0 drops valid, mode 1 changes data, while stalled.
        for (int mode = 0; mode < 2; mode++) begin
            do_start(40, 32'h0, 8'hFF);
            push_s.valid = 1'b1;
            push_s.data  = {$urandom, $urandom};
            push_s.strb  = 8'hFF;
            r = 1'b1;
            for (int w = 0; w < 60 && r; w++) begin
                @(negedge clk);
                r = push_s.ready;
                @(posedge clk);
                #1;
            end
            check("stall_found", r, 1'b0);
            if (mode == 0) push_s.valid = 1'b0;
            else push_s.data = ~push_s.data;
            @(posedge clk);
            #1;
            push_s.valid = 1'b0;
            @(negedge clk);
            check("err_set", err_o, PCHK);
            repeat (3) @(posedge clk);
            #1;
            check("err_sticky", err_o, PCHK);
            clear_i = 1'b1;
            @(posedge clk);
            #1;
            clear_i = 1'b0;
            @(negedge clk);
            check("err_cleared", err_o, 1'b0);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-transfer.
        beat_d.delete(); beat_s.delete();
        for (int i = 0; i < 3; i++) one_beat({$urandom, $urandom}, 8'hFF);
        do_start(30, 32'h0, 8'h00);
        send_beats(1'b0, cyc, ok);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_busy", busy_o, 1'b0);
        check("arst_cnt", beat_cnt_o, 16'h0);
        check("arst_sig", signature_o, 32'h0);
        check("arst_ready", push_s.ready, 1'b0);
        check("arst_done", done_o, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Zero-length transfer from IDLE after reset.
        beat_d.delete(); beat_s.delete();
        run_transfer(32'h0, 32'h1234_5678, 8'h00, 1'b0, cyc);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_sig_sink.md
# hwpe_stream_sig_sink

Synthesizable stream sink that terminates an `hwpe_stream_intf_stream` producer, such as the randomized stream source in the stream verification environment. It applies LFSR-driven pseudo-random backpressure and folds every accepted beat into a 32-bit rotating signature. After a programmed number of beats it reports beat count, signature and pass/fail against an expected value. It is the consumer stage used to close stream datapaths in unit benches and on-silicon self-test.

## Interface

Parameters:
- `DATA_WIDTH`, 32: stream data width; must be a multiple of 8.
- `CNT_WIDTH`, 16: width of the beat counter and length input.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk_i`  in  1: clock; one clock domain only.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `clear_i`  in  1: synchronous soft clear.
- `start_i`  in  1: start a transfer; `expected_len_i` and `expected_sig_i` are latched when it is accepted.
- `expected_len_i`  in  CNT_WIDTH: number of beats to accept.
- `expected_sig_i`  in  32: expected final signature.
- `stall_thr_i`  in  8: backpressure threshold; 0 means never stall.
- `push_i`  sink  `hwpe_stream_intf_stream` (DATA_WIDTH): input stream.
- `busy_o`  out  1: high in RUN.
- `done_o`  out  1: high in DONE.
- `match_o`  out  1: valid only when `done_o` is high; high when signature equals expected.
- `signature_o`  out  32: running signature.
- `beat_cnt_o`  out  CNT_WIDTH: beats accepted since start.
- `err_o`  out  1: sticky protocol error (see Configuration).

## Operation

- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - `start_i` latches the expected length and signature, zeroes the count and signature, and moves to RUN.
  - If the latched length is 0, the FSM moves to DONE instead.
- RUN:
  - A beat is accepted when `push_i.valid & push_i.ready`.
  - Each accepted beat increments `beat_cnt_o`.
  - Each accepted beat updates the signature: sig <= {sig[30:0], sig[31]} ^ fold(data masked by strb).
  - Masking zeroes byte k when `strb[k]` = 0.
  - fold() XORs consecutive 32-bit chunks of the masked data, zero-padding the top chunk.
  - The beat that makes the count equal to the latched length moves the FSM to DONE.
  - `start_i` is ignored in RUN.
- DONE:
  - Holds count and signature.
  - `match_o` = (sig == latched expected signature).
  - `start_i` starts a new transfer exactly as from IDLE.
- `clear_i` moves any state to IDLE next cycle and zeroes the count and signature.
  - `err_o` is cleared as well.
  - `clear_i` has priority over `start_i` and over a beat in the same cycle.
- Backpressure:
  - LFSR polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, shifting every cycle while in RUN.
  - `push_i.ready` = RUN & (lfsr[7:0] >= `stall_thr_i`).
  - `push_i.ready` is 0 in IDLE and DONE.
- Counter wrap cannot occur: the count stops at the latched length.

## Timing

- Reset values:
  - State = IDLE.
  - LFSR = `LFSR_SEED`.
  - `push_i.ready`, `busy_o`, `done_o`, `match_o`, `err_o` = 0.
  - `signature_o` = 0 and `beat_cnt_o` = 0.
- `push_i.ready` is derived from registers only. There is no combinational path from valid to ready.
- Beat counter and signature update in the cycle after the handshake edge. `done_o` rises in the same cycle as the final update.
- A start with nonzero length gives ready high at the earliest 1 cycle after `start_i`. A start with zero length gives `done_o` high 1 cycle after `start_i`.
- With `stall_thr_i` = 0, sustained throughput is 1 beat/cycle.
- Asserting `rst_ni` low mid-transfer immediately returns all outputs to their reset values. Partial results are lost.

## Configuration

- `HWPE_STREAM_SIG_SINK_PROTOCOL_CHECK_EN` defined: the block checks the stream protocol.
  - Applies in RUN when the previous cycle had `valid` = 1 and `ready` = 0.
  - The check fails if `valid` drops, or if `data` or `strb` changed.
  - A failure sets `err_o` sticky until `clear_i` or reset.
- Macro undefined: the checker is not built and `err_o` is tied to 0.

## Test plan

- DATA_WIDTH=32, len=2, full strb, beats 0x1 then 0x4, `stall_thr_i`=0 -> ready continuous; `signature_o`=0x6; `beat_cnt_o`=2; `done_o`=1; `match_o`=1 with expected 0x6, 0 with expected 0x7.
- Single beat 0xFFFFFFFF with strb 4'b0011 -> signature 0x0000FFFF.
- DATA_WIDTH=64, single beat 0x00000003_00000005, full strb -> signature 0x6 (32-bit fold).
- len=0 start -> `done_o` high 1 cycle later; ready never asserted; signature 0.
- `stall_thr_i`=0xFF, 1000 random beats with valid held -> ready duty cycle about 1/256; final signature matches the bench model; `clear_i` mid-transfer -> IDLE next cycle with count 0.
- With the macro defined: drop valid while ready=0 -> `err_o`=1 and stays high until `clear_i`. Without the macro: `err_o` stays 0.
